// File: rtl/param_router.sv
// Five-port mesh router: per-input FIFOs, XY routing, per-output round-robin
// arbitration with credit-based flow control and a registered output stage.
module param_router #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*ADDR_W-1:0]   myaddr_i,
  input  logic [5*DATA_W-1:0]   data_i,
  input  logic [4:0]            valid_i,
  input  logic [4:0]            incr_i,
  output logic [5*DATA_W-1:0]   data_o,
  output logic [4:0]            valid_o,
  output logic [4:0]            credit_o,
  output logic [4:0]            err_o
);

  localparam int unsigned NP    = 5;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(CREDITS);

  logic [DATA_W-1:0] r_mem [NP][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr  [NP];
  logic [PTR_W-1:0]  r_rd  [NP];
  logic [CNT_W-1:0]  r_cnt [NP];
  logic [CRD_W-1:0]  r_crd [NP];
  logic [2:0]        r_ptr [NP];

  logic [NP-1:0]     r_sv;
  logic [DATA_W-1:0] r_sd  [NP];
  logic [NP-1:0]     r_scr;

  logic [ADDR_W-1:0] w_mx;
  logic [ADDR_W-1:0] w_my;
  logic [DATA_W-1:0] w_head [NP];
  logic [ADDR_W-1:0] w_dx   [NP];
  logic [ADDR_W-1:0] w_dy   [NP];
  logic [2:0]        w_route[NP];
  logic [NP-1:0]     w_req  [NP];
  logic [2:0]        w_win  [NP];
  logic [NP-1:0]     w_gnt;
  logic [NP-1:0]     w_pop;
  logic [NP-1:0]     w_push_ok;

  // Wrapping index (base + k) mod 5 for the round-robin search.
  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int unsigned k);
    logic [3:0] s;
    s = {1'b0, base} + 4'(k);
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  assign w_mx = myaddr_i[2*ADDR_W-1 -: ADDR_W];
  assign w_my = myaddr_i[ADDR_W-1:0];

  // XY route decision on each FIFO head: X first, then Y, then local.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_head[p] = r_mem[p][r_rd[p]];
      w_dx[p]   = w_head[p][DATA_W-1 -: ADDR_W];
      w_dy[p]   = w_head[p][DATA_W-1-ADDR_W -: ADDR_W];
      if (w_dx[p] > w_mx)      w_route[p] = 3'd2;
      else if (w_dx[p] < w_mx) w_route[p] = 3'd3;
      else if (w_dy[p] > w_my) w_route[p] = 3'd0;
      else if (w_dy[p] < w_my) w_route[p] = 3'd1;
      else                     w_route[p] = 3'd4;
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        w_req[o][i] = (r_cnt[i] != '0) && (w_route[i] == 3'(o)) && (r_crd[o] != '0);
      end
    end
  end

  // Round-robin arbitration; each input requests a single output, so pops never collide.
  always_comb begin
    w_gnt = '0;
    w_pop = '0;
    for (int o = 0; o < NP; o++) begin
      w_win[o] = 3'd0;
      for (int k = 0; k < NP; k++) begin
        if (!w_gnt[o] && w_req[o][rr_idx(r_ptr[o], k)]) begin
          w_gnt[o] = 1'b1;
          w_win[o] = rr_idx(r_ptr[o], k);
        end
      end
      if (w_gnt[o]) w_pop[w_win[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      w_push_ok[i] = valid_i[i] && ((r_cnt[i] != FULL_CNT) || w_pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (w_push_ok[i]) r_mem[i][r_wr[i]] <= data_i[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
      end
      err_o <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (w_push_ok[i]) r_wr[i] <= r_wr[i] + PTR_W'(1);
        if (w_pop[i])     r_rd[i] <= r_rd[i] + PTR_W'(1);
        case ({w_push_ok[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      err_o <= err_o | (valid_i & ~w_push_ok);
    end
  end

  // Credits: grant and return in the same cycle cancel; returns saturate at CREDITS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        r_crd[o] <= CRD_MAX;
        r_ptr[o] <= 3'd0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        case ({w_gnt[o], incr_i[o]})
          2'b10:   r_crd[o] <= r_crd[o] - CRD_W'(1);
          2'b01:   if (r_crd[o] != CRD_MAX) r_crd[o] <= r_crd[o] + CRD_W'(1);
          default: r_crd[o] <= r_crd[o];
        endcase
        if (w_gnt[o]) r_ptr[o] <= rr_idx(w_win[o], 1);
      end
    end
  end

  // Two register stages: popped flit captured, then driven onto the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sv     <= '0;
      r_scr    <= '0;
      valid_o  <= '0;
      credit_o <= '0;
      data_o   <= '0;
      for (int o = 0; o < NP; o++) r_sd[o] <= '0;
    end else begin
      r_sv     <= w_gnt;
      r_scr    <= w_pop;
      valid_o  <= r_sv;
      credit_o <= r_scr;
      for (int o = 0; o < NP; o++) begin
        if (w_gnt[o]) r_sd[o] <= w_head[w_win[o]];
        if (r_sv[o])  data_o[o*DATA_W +: DATA_W] <= r_sd[o];
      end
    end
  end

endmodule

// File: tb/tb_param_router.sv
// Scoreboard bench for param_router: expectations queued per output at push time.
module tb_param_router;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  myaddr_i = 4'b0101;
  logic [39:0] data_i = '0;
  logic [4:0]  valid_i = '0;
  logic [4:0]  incr_i = '0;
  logic [39:0] data_o;
  logic [4:0]  valid_o;
  logic [4:0]  credit_o;
  logic [4:0]  err_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [5][$];
  logic [7:0] mon_e;

  param_router dut (
    .clk(clk), .rst(rst), .myaddr_i(myaddr_i), .data_i(data_i),
    .valid_i(valid_i), .incr_i(incr_i), .data_o(data_o),
    .valid_o(valid_o), .credit_o(credit_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Reference XY route for own address X=1, Y=1.
  function automatic int route_of(input logic [7:0] d);
    logic [1:0] dx;
    logic [1:0] dy;
    dx = d[7:6];
    dy = d[5:4];
    if (dx > 2'd1) return 2;
    if (dx < 2'd1) return 3;
    if (dy > 2'd1) return 0;
    if (dy < 2'd1) return 1;
    return 4;
  endfunction

  always @(negedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (valid_o[p]) begin
        checks++;
        if (exp_q[p].size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected out=%0d got=%h required=none", p, data_o[p*8 +: 8]);
        end else begin
          mon_e = exp_q[p].pop_front();
          if (data_o[p*8 +: 8] !== mon_e) begin
            errors++;
            $display("FAIL sb_data out=%0d got=%h required=%h", p, data_o[p*8 +: 8], mon_e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    valid_i = '0;
    incr_i  = '0;
  endtask

  task automatic send(input int p, input logic [7:0] d, input bit accept);
    data_i[p*8 +: 8] = d;
    valid_i[p] = 1'b1;
    if (accept) exp_q[route_of(d)].push_back(d);
  endtask

  task automatic flush_q();
    for (int p = 0; p < 5; p++) exp_q[p].delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_q();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic count_out(input int n, input int port, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (valid_o[port]) cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({valid_o, credit_o, err_o} !== 15'd0) begin
      errors++;
      $display("FAIL reset_flags got=%b_%b_%b required=0", valid_o, credit_o, err_o);
    end
    checks++;
    if (data_o !== 40'd0) begin
      errors++;
      $display("FAIL reset_data got=%h required=0", data_o);
    end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    send(4, 8'hC5, 1'b1);
    step();
    step();
    checks++;
    if (valid_o !== 5'b00000) begin
      errors++;
      $display("FAIL lat_early got=%b required=00000", valid_o);
    end
    step();
    checks++;
    if (valid_o !== 5'b00100 || data_o[23:16] !== 8'hC5 || credit_o !== 5'b10000) begin
      errors++;
      $display("FAIL lat_t2 got=v%b d%h c%b required=v00100 dc5 c10000", valid_o, data_o[23:16], credit_o);
    end
    step();
    checks++;
    if (valid_o !== 5'b00000 || credit_o !== 5'b00000 || data_o[23:16] !== 8'hC5) begin
      errors++;
      $display("FAIL lat_hold got=v%b c%b d%h required=v00000 c00000 dc5", valid_o, credit_o, data_o[23:16]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    send(0, 8'h5A, 1'b1);
    send(3, 8'h53, 1'b1);
    step();
    step();
    step();
    checks++;
    if (valid_o[4] !== 1'b1 || data_o[39:32] !== 8'h5A || credit_o !== 5'b00001) begin
      errors++;
      $display("FAIL rr_first got=v%b d%h c%b required=v1 d5a c00001", valid_o[4], data_o[39:32], credit_o);
    end
    step();
    checks++;
    if (valid_o[4] !== 1'b1 || data_o[39:32] !== 8'h53 || credit_o !== 5'b01000) begin
      errors++;
      $display("FAIL rr_second got=v%b d%h c%b required=v1 d53 c01000", valid_o[4], data_o[39:32], credit_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] vv;
    logic [9:0] cv;
    do_reset();
    vv = '0;
    cv = '0;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) send(2, 8'h40 + 8'(k), 1'b1);
      step();
      vv[k] = valid_o[1];
      cv[k] = credit_o[2];
    end
    checks++;
    if (vv !== 10'b0000111100 || cv !== 10'b0000111100) begin
      errors++;
      $display("FAIL b2b_pattern got=v%b c%b required=0000111100", vv, cv);
    end
  endtask

  task automatic test_credit_block();
    int cnt;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      send(4, 8'hE0 | 8'(i), 1'b1);
      step();
      if (valid_o[2]) cnt++;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (valid_o[2]) cnt++;
    end
    checks++;
    if (cnt !== 4) begin
      errors++;
      $display("FAIL credit_block got=%0d required=4", cnt);
    end
    incr_i[2] = 1'b1;
    step();
    step();
    checks++;
    if (valid_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL credit_early got=%b required=0", valid_o[2]);
    end
    step();
    checks++;
    if (valid_o[2] !== 1'b1 || data_o[23:16] !== 8'hE4) begin
      errors++;
      $display("FAIL credit_release got=v%b d%h required=v1 de4", valid_o[2], data_o[23:16]);
    end
    count_out(4, 2, cnt);
    checks++;
    if (cnt !== 0 || exp_q[2].size() !== 1) begin
      errors++;
      $display("FAIL credit_sixth got=out%0d left%0d required=out0 left1", cnt, exp_q[2].size());
    end
    flush_q();
  endtask

  task automatic test_saturate();
    int cnt;
    int c2;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      incr_i[2] = 1'b1;
      step();
    end
    for (int i = 0; i < 6; i++) begin
      send(4, 8'hC0 | 8'(i), 1'b1);
      step();
    end
    count_out(6, 2, cnt);
    count_out(0, 2, c2);
    checks++;
    if (exp_q[2].size() !== 2) begin
      errors++;
      $display("FAIL saturate got=left%0d required=left2", exp_q[2].size());
    end
    flush_q();
  endtask

  task automatic test_credit_simul();
    int cnt;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send(4, 8'hD0 | 8'(i), 1'b1);
      if (i > 0) incr_i[2] = 1'b1;
      step();
      if (valid_o[2]) cnt++;
    end
    incr_i[2] = 1'b1;
    step();
    if (valid_o[2]) cnt++;
    for (int i = 0; i < 5; i++) begin
      send(4, 8'hD8 | 8'(i), 1'b1);
      step();
      if (valid_o[2]) cnt++;
    end
    for (int k = 0; k < 6; k++) begin
      step();
      if (valid_o[2]) cnt++;
    end
    checks++;
    if (cnt !== 8 || exp_q[2].size() !== 1) begin
      errors++;
      $display("FAIL credit_simul got=out%0d left%0d required=out8 left1", cnt, exp_q[2].size());
    end
    flush_q();
  endtask

  task automatic test_overflow();
    int cnt;
    int c2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(4, 8'hC0 | 8'(i), 1'b1);
      step();
    end
    count_out(4, 2, cnt);
    for (int i = 0; i < 5; i++) begin
      send(1, 8'hF0 | 8'(i), i < 4);
      step();
    end
    checks++;
    if (err_o !== 5'b00010) begin
      errors++;
      $display("FAIL ovf_err got=%b required=00010", err_o);
    end
    count_out(4, 2, cnt);
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL ovf_blocked got=%0d required=0", cnt);
    end
    incr_i[2] = 1'b1;
    step();
    cnt = valid_o[2] ? 1 : 0;
    send(1, 8'hF8, 1'b1);
    step();
    if (valid_o[2]) cnt++;
    for (int k = 0; k < 4; k++) begin
      incr_i[2] = 1'b1;
      step();
      if (valid_o[2]) cnt++;
    end
    count_out(6, 2, c2);
    checks++;
    if (cnt + c2 !== 5 || exp_q[2].size() !== 0) begin
      errors++;
      $display("FAIL ovf_drain got=out%0d left%0d required=out5 left0", cnt + c2, exp_q[2].size());
    end
    checks++;
    if (err_o !== 5'b00010) begin
      errors++;
      $display("FAIL ovf_sticky got=%b required=00010", err_o);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(4, 8'hC0 | 8'(i), 1'b1);
      step();
    end
    count_out(4, 2, cnt);
    for (int i = 0; i < 3; i++) begin
      send(4, 8'hD0 | 8'(i), 1'b0);
      step();
    end
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, credit_o, err_o} !== 15'd0 || data_o !== 40'd0) begin
      errors++;
      $display("FAIL mid_reset got=v%b c%b e%b d%h required=0", valid_o, credit_o, err_o, data_o);
    end
    flush_q();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send(4, 8'hC5, 1'b1);
    step();
    step();
    checks++;
    if (valid_o !== 5'b00000 || credit_o !== 5'b00000) begin
      errors++;
      $display("FAIL mid_stale got=v%b c%b required=0", valid_o, credit_o);
    end
    step();
    checks++;
    if (valid_o !== 5'b00100 || data_o[23:16] !== 8'hC5 || credit_o !== 5'b10000) begin
      errors++;
      $display("FAIL mid_new got=v%b d%h c%b required=v00100 dc5 c10000", valid_o, data_o[23:16], credit_o);
    end
    for (int i = 0; i < 3; i++) begin
      send(4, 8'hE0 | 8'(i), 1'b1);
      step();
    end
    count_out(6, 2, cnt);
    checks++;
    if (exp_q[2].size() !== 0) begin
      errors++;
      $display("FAIL mid_credits got=left%0d required=left0", exp_q[2].size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_back_to_back();
    test_credit_block();
    test_saturate();
    test_credit_simul();
    test_overflow();
    test_reset_mid();
    step();
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (exp_q[p].size() !== 0) begin
        errors++;
        $display("FAIL sb_leftover out=%0d got=%0d required=0", p, exp_q[p].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
